// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller for a 5-stage MIPS datapath: load-use stalls, redirect flushes,
// EX forwarding selects, WB-to-ID bypass and saturating debug event counters.
`timescale 1ns/1ps

module hazard_sequencer #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic [4:0]       EX_Rs,
    input  logic [4:0]       EX_Rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WriteReg,
    input  logic             M_RegWrite,
    input  logic [4:0]       M_WriteReg,
    input  logic             WB_RegWrite,
    input  logic [4:0]       WB_WriteReg,
    input  logic             M_Redirect,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic             ID_BypA,
    output logic             ID_BypB,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             State
);

    localparam int SC_W = $clog2(LOAD_STALL_CYCLES + 1);
    localparam int RELOAD_INT = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0;
    localparam logic [SC_W-1:0] STALL_RELOAD = SC_W'(RELOAD_INT);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t          state_q;
    logic [SC_W-1:0] stall_cnt;

    logic m_wr_valid;
    logic wb_wr_valid;
    logic m_hit_a;
    logic m_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;
    logic load_use;
    logic stall;

    assign m_wr_valid  = M_RegWrite  && (M_WriteReg  != 5'd0);
    assign wb_wr_valid = WB_RegWrite && (WB_WriteReg != 5'd0);

    assign m_hit_a  = m_wr_valid  && (M_WriteReg  == EX_Rs);
    assign m_hit_b  = m_wr_valid  && (M_WriteReg  == EX_Rt);
    assign wb_hit_a = wb_wr_valid && (WB_WriteReg == EX_Rs);
    assign wb_hit_b = wb_wr_valid && (WB_WriteReg == EX_Rt);

    assign load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
                      ((ID_UsesRs && (EX_WriteReg == ID_Rs)) ||
                       (ID_UsesRt && (EX_WriteReg == ID_Rt)));

    // A redirect kills whatever was stalled, so it always masks the stall request.
    assign stall = !M_Redirect && ((state_q == STALL) || load_use);

    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        FwdA        = 2'b00;
        FwdB        = 2'b00;
        ID_BypA     = 1'b0;
        ID_BypB     = 1'b0;
        if (!Reset) begin
            if (M_Redirect) begin
                IFID_Flush  = 1'b1;
                IDEX_Flush  = 1'b1;
                EXMEM_Flush = 1'b1;
            end else if (stall) begin
                PCWrite     = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Flush  = 1'b1;
            end

            if (m_hit_a)       FwdA = 2'b10;
            else if (wb_hit_a) FwdA = 2'b01;
            if (m_hit_b)       FwdB = 2'b10;
            else if (wb_hit_b) FwdB = 2'b01;

            ID_BypA = wb_wr_valid && (WB_WriteReg == ID_Rs);
            ID_BypB = wb_wr_valid && (WB_WriteReg == ID_Rt);
        end
    end

    assign State = state_q;

    // stall_cnt holds the number of bubbles still owed after the current STALL cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= RUN;
            stall_cnt  <= '0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (M_Redirect) begin
                        if (FlushCount != '1) FlushCount <= FlushCount + CNT_W'(1);
                    end else if (load_use) begin
                        if (StallCount != '1) StallCount <= StallCount + CNT_W'(1);
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_q   <= STALL;
                            stall_cnt <= STALL_RELOAD;
                        end
                    end
                end
                STALL: begin
                    if (M_Redirect) begin
                        state_q   <= RUN;
                        stall_cnt <= '0;
                        if (FlushCount != '1) FlushCount <= FlushCount + CNT_W'(1);
                    end else begin
                        if (StallCount != '1) StallCount <= StallCount + CNT_W'(1);
                        if (stall_cnt == '0) state_q <= RUN;
                        else                 stall_cnt <= stall_cnt - SC_W'(1);
                    end
                end
                default: begin
                    state_q   <= RUN;
                    stall_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized and directed checks of hazard_sequencer against a bubbles-owed reference model,
// using one instance with single-cycle stalls and one with 3-cycle stalls and narrow counters.
`timescale 1ns/1ps

module tb_hazard_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_WriteReg, M_WriteReg, WB_WriteReg;
    logic       ID_UsesRs, ID_UsesRt, EX_MemRead, M_RegWrite, WB_RegWrite, M_Redirect;

    logic        a_pc, a_ifw, a_iff, a_idf, a_exf, a_bya, a_byb, a_state;
    logic [1:0]  a_fa, a_fb;
    logic [31:0] a_sc, a_fc;
    logic        b_pc, b_ifw, b_iff, b_idf, b_exf, b_bya, b_byb, b_state;
    logic [1:0]  b_fa, b_fb;
    logic [3:0]  b_sc, b_fc;

    int checks = 0;
    int failures = 0;

    // Model: bubbles still owed after this cycle, plus saturating counters.
    int     rem[2];
    longint sc[2];
    longint fc[2];
    longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};
    int     lsc[2]  = '{1, 3};

    always #5 Clk = ~Clk;

    hazard_sequencer #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u_a (
        .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs),
        .ID_UsesRt(ID_UsesRt), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead),
        .EX_WriteReg(EX_WriteReg), .M_RegWrite(M_RegWrite), .M_WriteReg(M_WriteReg),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .M_Redirect(M_Redirect),
        .PCWrite(a_pc), .IFID_Write(a_ifw), .IFID_Flush(a_iff), .IDEX_Flush(a_idf),
        .EXMEM_Flush(a_exf), .FwdA(a_fa), .FwdB(a_fb), .ID_BypA(a_bya), .ID_BypB(a_byb),
        .StallCount(a_sc), .FlushCount(a_fc), .State(a_state)
    );

    hazard_sequencer #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u_b (
        .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs),
        .ID_UsesRt(ID_UsesRt), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead),
        .EX_WriteReg(EX_WriteReg), .M_RegWrite(M_RegWrite), .M_WriteReg(M_WriteReg),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .M_Redirect(M_Redirect),
        .PCWrite(b_pc), .IFID_Write(b_ifw), .IFID_Flush(b_iff), .IDEX_Flush(b_idf),
        .EXMEM_Flush(b_exf), .FwdA(b_fa), .FwdB(b_fb), .ID_BypA(b_bya), .ID_BypB(b_byb),
        .StallCount(b_sc), .FlushCount(b_fc), .State(b_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (M_RegWrite && M_WriteReg != 0 && M_WriteReg == src) return 2'b10;
        if (WB_RegWrite && WB_WriteReg != 0 && WB_WriteReg == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic lu_model();
        return EX_MemRead && EX_WriteReg != 0 &&
               ((ID_UsesRs && EX_WriteReg == ID_Rs) || (ID_UsesRt && EX_WriteReg == ID_Rt));
    endfunction

    // {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, FwdA, FwdB, BypA, BypB}
    function automatic logic [10:0] exp_comb(input int i);
        logic st;
        logic bya, byb;
        if (Reset) return {5'b11000, 6'b0};
        st  = !M_Redirect && (rem[i] > 0 || lu_model());
        bya = WB_RegWrite && WB_WriteReg != 0 && WB_WriteReg == ID_Rs;
        byb = WB_RegWrite && WB_WriteReg != 0 && WB_WriteReg == ID_Rt;
        return {!st, !st, M_Redirect, M_Redirect | st, M_Redirect,
                fwd_model(EX_Rs), fwd_model(EX_Rt), bya, byb};
    endfunction

    function automatic longint sat_inc(input longint v, input longint mx);
        return (v == mx) ? v : v + 1;
    endfunction

    task automatic model_step();
        logic lu;
        lu = lu_model();
        for (int i = 0; i < 2; i++) begin
            if (rem[i] == 0) begin
                if (M_Redirect) fc[i] = sat_inc(fc[i], cmax[i]);
                else if (lu) begin
                    sc[i]  = sat_inc(sc[i], cmax[i]);
                    rem[i] = lsc[i] - 1;
                end
            end else if (M_Redirect) begin
                rem[i] = 0;
                fc[i]  = sat_inc(fc[i], cmax[i]);
            end else begin
                sc[i]  = sat_inc(sc[i], cmax[i]);
                rem[i] = rem[i] - 1;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; sc[i] = 0; fc[i] = 0;
        end
    endtask

    task automatic cmp_comb();
        chk("a_comb", {a_pc, a_ifw, a_iff, a_idf, a_exf, a_fa, a_fb, a_bya, a_byb}, exp_comb(0));
        chk("b_comb", {b_pc, b_ifw, b_iff, b_idf, b_exf, b_fa, b_fb, b_bya, b_byb}, exp_comb(1));
    endtask

    task automatic cmp_regs();
        chk("a_state", a_state, rem[0] > 0);
        chk("a_stallcnt", a_sc, sc[0]);
        chk("a_flushcnt", a_fc, fc[0]);
        chk("b_state", b_state, rem[1] > 0);
        chk("b_stallcnt", b_sc, sc[1]);
        chk("b_flushcnt", b_fc, fc[1]);
    endtask

    // Entered just after a falling edge with inputs already applied; leaves on the next falling edge.
    task automatic cycle();
        #1 cmp_comb();
        @(posedge Clk);
        model_step();
        #1 cmp_regs();
        @(negedge Clk);
    endtask

    task automatic idle();
        ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0; EX_Rs = 0; EX_Rt = 0;
        EX_MemRead = 0; EX_WriteReg = 0; M_RegWrite = 0; M_WriteReg = 0;
        WB_RegWrite = 0; WB_WriteReg = 0; M_Redirect = 0;
    endtask

    task automatic load_use_in();
        idle();
        EX_MemRead = 1; EX_WriteReg = 2; ID_Rs = 2; ID_UsesRs = 1; ID_Rt = 4; ID_UsesRt = 1;
    endtask

    // Asynchronous reset pulse asserted mid-cycle; registers must clear before any edge.
    task automatic pulse_reset();
        Reset = 1;
        model_reset();
        #1 cmp_regs();
        cmp_comb();
        @(negedge Clk);
        Reset = 0;
    endtask

    initial begin
        idle();
        Reset = 1;
        model_reset();
        #1 cmp_regs();
        cmp_comb();
        chk("rst_pcwrite", a_pc, 1'b1);
        @(negedge Clk);
        Reset = 0;

        // lw $2 in EX, add $3,$2,$4 in ID
        load_use_in();
        #1 chk("tp1_pcwrite", a_pc, 1'b0);
        chk("tp1_idex_flush", a_idf, 1'b1);
        cycle();
        chk("tp1_sc_model", sc[0], 1);
        idle(); ID_Rs = 2; ID_UsesRs = 1; M_RegWrite = 1; M_WriteReg = 2;
        #1 chk("tp1_resume_pc", a_pc, 1'b1);
        chk("tp1_mem_fwda", a_fa, 2'b00);
        cycle();
        idle(); EX_Rs = 2; WB_RegWrite = 1; WB_WriteReg = 2;
        #1 chk("tp1_wb_fwda", a_fa, 2'b01);
        cycle();

        // Forwarding priority and register 0
        idle(); EX_Rs = 5; M_RegWrite = 1; M_WriteReg = 5; WB_RegWrite = 1; WB_WriteReg = 5;
        #1 chk("tp2_mem_prio", a_fa, 2'b10);
        cycle();
        idle(); EX_Rs = 5; WB_RegWrite = 1; WB_WriteReg = 5;
        #1 chk("tp2_wb_only", a_fa, 2'b01);
        cycle();
        idle(); M_RegWrite = 1; M_WriteReg = 0; EX_Rt = 0;
        #1 chk("tp2_r0_fwdb", a_fb, 2'b00);
        cycle();

        // Redirect in RUN
        pulse_reset();
        idle(); M_Redirect = 1;
        #1 chk("tp3_flushes", {a_iff, a_idf, a_exf, a_pc}, 4'b1111);
        cycle();
        idle();
        cycle();
        chk("tp3_fc_model", fc[0], 1);
        chk("tp3_sc_model", sc[0], 0);

        // Three-cycle stall, then a stall cut short by a redirect
        pulse_reset();
        load_use_in();
        cycle();
        idle();
        #1 chk("tp4_stall2_pc", b_pc, 1'b0);
        cycle();
        cycle();
        cycle();
        chk("tp4_sc_model", sc[1], 3);
        pulse_reset();
        load_use_in();
        cycle();
        idle(); M_Redirect = 1;
        #1 chk("tp4_redir_flush", b_exf, 1'b1);
        cycle();
        chk("tp4_state_after", b_state, 1'b0);
        chk("tp4_sc_redir", sc[1], 1);

        // Load-use and redirect together
        pulse_reset();
        load_use_in(); M_Redirect = 1;
        cycle();
        idle();
        cycle();
        chk("tp5_sc_model", sc[1], 0);
        chk("tp5_fc_model", fc[1], 1);

        // Reset during STALL, then bypass
        pulse_reset();
        load_use_in();
        cycle();
        idle();
        #1 Reset = 1;
        #1 chk("tp6_async_state", b_state, 1'b0);
        chk("tp6_async_sc", b_sc, 4'd0);
        model_reset();
        @(negedge Clk);
        Reset = 0;
        #1 chk("tp6_no_bubble", b_pc, 1'b1);
        cycle();
        idle(); ID_Rs = 7; WB_RegWrite = 1; WB_WriteReg = 7;
        #1 chk("tp6_bypa", a_bya, 1'b1);
        cycle();
        WB_WriteReg = 0; ID_Rs = 0;
        #1 chk("tp6_bypa_r0", a_bya, 1'b0);
        cycle();

        // Six hazards: 18 bubbles on the 4-bit instance saturate at 15
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            load_use_in();
            cycle();
            idle();
            cycle();
            cycle();
        end
        chk("sat_sc_model_b", sc[1], 15);
        chk("sat_sc_model_a", sc[0], 6);

        // Randomized traffic over a small register range so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                ID_Rs       = 5'($urandom_range(0, 3));
                ID_Rt       = 5'($urandom_range(0, 3));
                ID_UsesRs   = 1'($urandom_range(0, 1));
                ID_UsesRt   = 1'($urandom_range(0, 1));
                EX_Rs       = 5'($urandom_range(0, 3));
                EX_Rt       = 5'($urandom_range(0, 3));
                EX_MemRead  = 1'($urandom_range(0, 1));
                EX_WriteReg = 5'($urandom_range(0, 3));
                M_RegWrite  = 1'($urandom_range(0, 1));
                M_WriteReg  = 5'($urandom_range(0, 3));
                WB_RegWrite = 1'($urandom_range(0, 1));
                WB_WriteReg = 5'($urandom_range(0, 3));
                M_Redirect  = ($urandom_range(0, 9) == 0);
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath (IF/ID/EX/MEM/WB).
- Detects load-use hazards and inserts bubbles through a counted stall FSM.
- Flushes younger stages when a branch, jump or jr redirect resolves in MEM.
- Drives EX-stage forwarding selects and WB-to-ID bypass flags, and keeps saturating stall and flush event counters for debug.

Parameters:
- LOAD_STALL_CYCLES, 1, bubble cycles per load-use hazard (>=1).
- CNT_W, 32, width of the event counters.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ID_Rs, ID_Rt  input  5 each  source registers of the instruction in ID.
- ID_UsesRs, ID_UsesRt  input  1 each  ID instruction actually reads Rs / Rt.
- EX_Rs, EX_Rt  input  5 each  source registers of the instruction in EX.
- EX_MemRead  input  1  EX instruction is a load.
- EX_WriteReg  input  5  destination register in EX.
- M_RegWrite  input  1  MEM instruction writes a register.
- M_WriteReg  input  5  destination register in MEM.
- WB_RegWrite  input  1  WB instruction writes a register.
- WB_WriteReg  input  5  destination register in WB.
- M_Redirect  input  1  branch taken, jump or jr resolved in MEM; PC loads the target this cycle.
- PCWrite  output  1  PC update enable.
- IFID_Write  output  1  IF/ID register update enable.
- IFID_Flush, IDEX_Flush, EXMEM_Flush  output  1 each  clear the stage register to a bubble (all controls 0).
- FwdA, FwdB  output  2 each  ALU operand A/B source select: 00 = register file, 10 = MEM ALU result, 01 = WB write data.
- ID_BypA, ID_BypB  output  1 each  substitute WB write data for the ID Read1 / Read2 value.
- StallCount  output  CNT_W  stall cycles inserted.
- FlushCount  output  CNT_W  redirect events seen.
- State  output  1  0 = RUN, 1 = STALL.

Behaviour:
- Reset values (asynchronous):
  - State = RUN, internal stall counter = 0, StallCount = 0, FlushCount = 0.
  - While Reset is high, outputs are forced to PCWrite=1, IFID_Write=1, all Flush=0, FwdA=FwdB=00, ID_BypA=ID_BypB=0.
- Forwarding (combinational, independent of State):
  - FwdA = 10 when M_RegWrite, M_WriteReg != 0 and M_WriteReg == EX_Rs.
  - Otherwise FwdA = 01 when WB_RegWrite, WB_WriteReg != 0 and WB_WriteReg == EX_Rs.
  - Otherwise FwdA = 00.
  - FwdB uses the same rules against EX_Rt. MEM has priority over WB.
- ID bypass (combinational): ID_BypA = WB_RegWrite & (WB_WriteReg != 0) & (WB_WriteReg == ID_Rs). ID_BypB uses the same rule against ID_Rt.
- Load-use detect (combinational): lu = EX_MemRead & (EX_WriteReg != 0) & ((ID_UsesRs & EX_WriteReg == ID_Rs) | (ID_UsesRt & EX_WriteReg == ID_Rt)).
- Stall outputs: when stall is active, PCWrite=0, IFID_Write=0, IDEX_Flush=1.
- Redirect outputs: when M_Redirect=1, PCWrite=1, IFID_Write=1, and IFID_Flush=IDEX_Flush=EXMEM_Flush=1 in the same cycle, zero latency.
- Priority: redirect overrides stall in every state.
- RUN state:
  - M_Redirect: apply the redirect, stay in RUN, FlushCount++.
  - else lu: stall this cycle, StallCount++. If LOAD_STALL_CYCLES > 1, go to STALL with counter = LOAD_STALL_CYCLES-2; otherwise stay in RUN.
  - else: PCWrite=1, IFID_Write=1, no flushes.
- STALL state:
  - M_Redirect: apply the redirect, go to RUN, clear the counter, FlushCount++, no stall increment.
  - else: stall regardless of lu, StallCount++. If counter == 0, go to RUN; otherwise counter--.
- Counters saturate at all-ones and do not wrap.
- Register 0 never triggers a stall, forward or bypass.
- Reset asserted mid-stall returns to RUN immediately; no residual bubble after release.
- Simultaneous lu and M_Redirect: the redirect wins, no stall is counted, and the stalled instruction is flushed.

Test Plan:
1. Reset with LOAD_STALL_CYCLES=1: lw $2 in EX with ID add $3,$2,$4 -> one cycle of PCWrite=0/IFID_Write=0/IDEX_Flush=1, StallCount=1, then PCWrite=1. Next cycle the lw is in MEM: FwdA=10 is not expected; WB forwarding gives FwdA=01 two cycles after detection.
2. MEM add writing $5 and WB add writing $5, EX_Rs=5 -> FwdA=10. With only WB writing $5 -> FwdA=01. With EX_Rt=0 and M_WriteReg=0 -> FwdB=00.
3. M_Redirect=1 for one cycle in RUN -> all three Flush=1 and PCWrite=1 that cycle, FlushCount increments by 1, StallCount unchanged.
4. LOAD_STALL_CYCLES=3, load-use detected -> 3 consecutive stall cycles (State=1 for 2 cycles) and StallCount=3. Repeat with M_Redirect on the 2nd stall cycle -> flush asserted, State=0 next cycle, StallCount=1.
5. lu and M_Redirect in the same cycle -> no stall, flush asserted, StallCount=0, FlushCount=1.
6. Reset asserted during STALL -> State=0 and counters=0 asynchronously (before the next edge). WB_WriteReg=7 with ID_Rs=7 and WB_RegWrite=1 -> ID_BypA=1; with WB_WriteReg=0 -> ID_BypA=0.
